// File: rtl/cpu_mul_seq.sv
// Sequential 32x32 multiplier built on a shared, registered 16x16 unsigned multiplier.
// Signed high-word variants are produced by correcting the unsigned 64-bit product.
module cpu_mul_seq #(
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [OP_W-1:0] start_op,
  input  logic [31:0]     start_src1,
  input  logic [31:0]     start_src2,
  input  logic            flush,
  output logic [15:0]     pp_a,
  output logic [15:0]     pp_b,
  input  logic [31:0]     pp_result,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [31:0]     done_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CORR  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      r_state;
  logic [OP_W-1:0] r_op;
  logic [31:0]     r_src1;
  logic [31:0]     r_src2;
  logic [1:0]      r_cnt;
  logic            r_pend;
  logic [1:0]      r_pend_idx;
  logic [63:0]     r_acc;

  logic [2:0]  w_state_nxt;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_signed1;
  logic        w_signed2;
  logic        w_last_issue;
  logic [63:0] w_pp_ext;
  logic [63:0] w_acc_add;
  logic [63:0] w_corr1;
  logic [63:0] w_corr2;
  logic [63:0] w_acc_corr;

  assign w_accept     = start_valid && (r_state == S_IDLE);
  assign w_is_mul     = (r_op == OP_W'(0));
  assign w_signed1    = (r_op == OP_W'(2)) || (r_op == OP_W'(3));
  assign w_signed2    = (r_op == OP_W'(3));
  assign w_last_issue = w_is_mul ? (r_cnt == 2'd2) : (r_cnt == 2'd3);

  // Align the returning partial product by the index of the issue it belongs to.
  always_comb begin
    w_pp_ext = 64'd0;
    case (r_pend_idx)
      2'd0:    w_pp_ext = {32'd0, pp_result};
      2'd1:    w_pp_ext = {16'd0, pp_result, 16'd0};
      2'd2:    w_pp_ext = {16'd0, pp_result, 16'd0};
      2'd3:    w_pp_ext = {pp_result, 32'd0};
      default: w_pp_ext = 64'd0;
    endcase
  end

  assign w_acc_add  = r_acc + w_pp_ext;
  // Two's-complement fix-up: a negative operand contributes -(other << 32) to the unsigned product.
  assign w_corr1    = (w_signed1 && r_src1[31]) ? {r_src2, 32'd0} : 64'd0;
  assign w_corr2    = (w_signed2 && r_src2[31]) ? {r_src1, 32'd0} : 64'd0;
  assign w_acc_corr = r_acc - w_corr1 - w_corr2;

  // Next-state decode; flush outside IDLE always wins and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_valid) w_state_nxt = S_ISSUE;
        else             w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        if (w_last_issue) w_state_nxt = S_DRAIN;
        else              w_state_nxt = S_ISSUE;
      end
      S_DRAIN: begin
        if (w_is_mul) w_state_nxt = S_DONE;
        else          w_state_nxt = S_CORR;
      end
      S_CORR:  w_state_nxt = S_DONE;
      S_DONE: begin
        if (done_ready) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    else                              w_state_nxt = w_state_nxt;
  end

  // Sequencer state, captured request, issue counter and 64-bit accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_src1     <= 32'd0;
      r_src2     <= 32'd0;
      r_cnt      <= 2'd0;
      r_pend     <= 1'b0;
      r_pend_idx <= 2'd0;
      r_acc      <= 64'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= (r_state == S_ISSUE) && !flush;
      r_pend_idx <= r_cnt;
      if (w_accept) begin
        r_op   <= start_op;
        r_src1 <= start_src1;
        r_src2 <= start_src2;
        r_cnt  <= 2'd0;
        r_acc  <= 64'd0;
      end else begin
        if (r_state == S_ISSUE) r_cnt <= r_cnt + 2'd1;
        else                    r_cnt <= r_cnt;
        if (r_state == S_CORR) r_acc <= w_acc_corr;
        else if (r_pend)       r_acc <= w_acc_add;
        else                   r_acc <= r_acc;
      end
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign done_result = (r_state == S_DONE) ? (w_is_mul ? r_acc[31:0] : r_acc[63:32]) : 32'd0;
  assign pp_a        = (r_state == S_ISSUE) ? (r_cnt[0] ? r_src1[31:16] : r_src1[15:0]) : 16'd0;
  assign pp_b        = (r_state == S_ISSUE) ? (r_cnt[1] ? r_src2[31:16] : r_src2[15:0]) : 16'd0;

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Directed bench for cpu_mul_seq with a registered 16x16 multiplier model.
module tb_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [1:0]  start_op = 2'd0;
  logic [31:0] start_src1 = 32'd0;
  logic [31:0] start_src2 = 32'd0;
  logic        flush = 1'b0;
  logic [15:0] pp_a;
  logic [15:0] pp_b;
  logic [31:0] pp_result = 32'd0;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic [31:0] done_result;

  int n_cmp = 0;
  int n_err = 0;

  cpu_mul_seq #(.OP_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_op(start_op),
    .start_src1(start_src1), .start_src2(start_src2), .flush(flush),
    .pp_a(pp_a), .pp_b(pp_b), .pp_result(pp_result),
    .done_valid(done_valid), .done_ready(done_ready), .done_result(done_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pp_result <= 32'(pp_a) * 32'(pp_b);

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2);
    @(negedge clk);
    start_op    = op;
    start_src1  = s1;
    start_src2  = s2;
    start_valid = 1'b1;
    chk("start_ready_at_accept", 32'(start_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] s1,
                     input logic [31:0] s2, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    issue(op, s1, s2);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, done_result, exp_res);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(start_ready), 32'd1);
    chk({tag, "_dv_after"}, 32'(done_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_result", done_result, 32'd0);
    chk("rst_pp_a", 32'(pp_a), 32'd0);
    chk("rst_pp_b", 32'(pp_b), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // First acceptance in the first clock after release; check first issue operands.
    issue(2'd0, 32'h0001_0003, 32'h0002_0005);
    chk("mul_pp_a_c1", 32'(pp_a), 32'd3);
    chk("mul_pp_b_c1", 32'(pp_b), 32'd5);
    wait_done(lat);
    chk("mul_latency", 32'(lat), 32'd5);
    chk("mul_result", done_result, 32'h000B_000F);
    @(posedge clk);
    @(negedge clk);
    chk("mul_ready_after", 32'(start_ready), 32'd1);
    chk("mul_pp_a_idle", 32'(pp_a), 32'd0);

    run("mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 32'hFFFF_FFFE);
    run("mulxss_m1x2", 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 7, 32'hFFFF_FFFF);
    run("mulxss_m1xm1", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 32'h0000_0000);
    run("mulxsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 32'hFFFF_FFFF);
    run("mulxsu_2xff", 2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 7, 32'h0000_0001);

    // Consumer stall: result must hold for three cycles.
    done_ready = 1'b0;
    issue(2'd2, 32'h8000_0000, 32'h0000_0003);
    wait_done(lat);
    chk("stall_latency", 32'(lat), 32'd7);
    chk("stall_result", done_result, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_dv_hold", 32'(done_valid), 32'd1);
      chk("stall_res_hold", done_result, 32'hFFFF_FFFE);
      chk("stall_ready_low", 32'(start_ready), 32'd0);
    end
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_ready_after", 32'(start_ready), 32'd1);
    chk("stall_dv_after", 32'(done_valid), 32'd0);

    // Flush in IDLE is ignored and the concurrent request is accepted.
    flush = 1'b1;
    run("flush_idle_mul", 2'd0, 32'h0000_1234, 32'h0000_0010, 5, 32'h0001_2340);

    // Flush at cycle 3 of a MULXSS aborts it.
    issue(2'd3, 32'hFFFF_FFFF, 32'h0000_0002);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_c4", 32'(start_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | done_valid;
      @(negedge clk);
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    run("after_flush_mul", 2'd0, 32'd7, 32'd6, 5, 32'h0000_002A);

    // Reset at cycle 2 aborts immediately.
    issue(2'd1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_start_ready", 32'(start_ready), 32'd1);
    chk("midrst_done_valid", 32'(done_valid), 32'd0);
    chk("midrst_done_result", done_result, 32'd0);
    chk("midrst_pp_a", 32'(pp_a), 32'd0);
    chk("midrst_pp_b", 32'(pp_b), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | done_valid;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run("after_rst_mulxuu", 2'd1, 32'h0001_0000, 32'h0001_0000, 7, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mul_seq.md
CPU_MUL_SEQ -- requirements
Module: cpu_mul_seq

Interface
REQ-001 SHALL have parameter OP_W, default 2, meaning the width of the start_op field.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_valid, input, 1, meaning a multiply request is present.
REQ-005 SHALL have port start_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 SHALL have port start_op, input, OP_W, with encoding 0=MUL (low word), 1=MULXUU, 2=MULXSU, 3=MULXSS (high word).
REQ-007 SHALL have ports start_src1 and start_src2, input, 32 each, the operands.
REQ-008 SHALL have port flush, input, 1, a synchronous abort of the operation in flight.
REQ-009 SHALL have ports pp_a and pp_b, output, 16 each, the operands driven to the shared 16x16 unsigned multiplier.
REQ-010 SHALL have port pp_result, input, 32, the multiplier product, valid one cycle after its operands are driven (registered multiplier).
REQ-011 SHALL have port done_valid, output, 1, meaning the result is available.
REQ-012 SHALL have port done_ready, input, 1, meaning the consumer takes the result.
REQ-013 SHALL have port done_result, output, 32, the result word.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, CORR and DONE.
REQ-015 SHALL assert start_ready only in IDLE; acceptance SHALL be start_valid && start_ready (cycle 0), and SHALL capture op, src1 and src2 into internal registers.
REQ-016 In ISSUE, starting at cycle 1, SHALL drive one partial product per cycle in the fixed order a_lo*b_lo, a_hi*b_lo, a_lo*b_hi, a_hi*b_hi; MUL SHALL issue only the first three.
REQ-017 SHALL accumulate each pp_result, one cycle after its issue, into a 64-bit unsigned accumulator, shifted left by 0, 16, 16 and 32 bits respectively; the accumulator SHALL be cleared on acceptance.
REQ-018 SHALL spend one DRAIN cycle after the last issue to absorb the final product.
REQ-019 In CORR (MULX* only), SHALL subtract src2<<32 from the accumulator when the op is signed-src1 and src1[31]=1, and SHALL subtract src1<<32 when the op is MULXSS and src2[31]=1; MULXUU SHALL pass through CORR unchanged. All arithmetic SHALL be modulo 2^64.
REQ-020 MUL SHALL skip CORR.
REQ-021 SHALL assert done_valid at cycle 5 after acceptance for MUL and at cycle 7 after acceptance for MULX*, independent of operand values.
REQ-022 SHALL set done_result to accumulator[31:0] for MUL and to accumulator[63:32] for MULX*.
REQ-023 SHALL hold done_valid and done_result stable in DONE until done_ready=1.
REQ-024 SHALL return to IDLE on the cycle after the done handshake; back-to-back acceptance SHALL be possible no earlier than that IDLE cycle.
REQ-025 SHALL drive pp_a and pp_b to 0 when not in ISSUE.
REQ-026 flush=1 in any non-IDLE state SHALL return the block to IDLE on the next edge, with no done_valid for the aborted operation. If done_valid and done_ready are also 1 in the same cycle, the handshake SHALL complete and flush SHALL have no further effect.
REQ-027 flush in IDLE SHALL be ignored, and a request presented in the same cycle SHALL be accepted.
REQ-028 SHALL ignore pp_result in all cycles other than the one following each issue.

Reset
REQ-029 While reset_n=0, SHALL hold state=IDLE, start_ready=1, done_valid=0, done_result=0, pp_a=0, pp_b=0, and accumulator and captured operands at 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no done_valid after release.
REQ-031 The first acceptance SHALL be possible in the first clock after reset_n rises.

Verification
REQ-032 MUL with src1=0x00010003, src2=0x00020005 -> done_valid at cycle 5, done_result=0x000B000F.
REQ-033 MULXUU with 0xFFFFFFFF x 0xFFFFFFFF -> done_valid at cycle 7, done_result=0xFFFFFFFE.
REQ-034 MULXSS -1 x 2 -> 0xFFFFFFFF; MULXSS -1 x -1 -> 0x00000000; MULXSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 Hold done_ready=0 for 3 cycles -> done_valid and done_result stable and start_ready=0 throughout; start_ready=1 the cycle after done_ready=1.
REQ-036 Pulse flush at cycle 3 of a MULXSS -> IDLE at cycle 4, no done_valid; a following MUL 7 x 6 -> done_result=0x0000002A.
REQ-037 Drive reset_n=0 at cycle 2 of an operation -> all outputs at reset values immediately; after release, MULXUU 0x10000 x 0x10000 -> done_result=0x00000001.
